fire9_squeeze_ofm_writer: RTL and testbench

Downstream stage of the fire9 squeeze convolution. Captures the DSP_NO parallel post-ReLU squeeze outputs on each sample strobe and serialises them, one word per clock, into the channel-major feature-map RAM read by the fire9 expand layers. After all WOUT² output pixels are stored, it raises the `ram_feedback` pulse that the squeeze stage uses to release its finish flag.

---
 rtl/fire9_squeeze_ofm_writer_if.sv | 42 ++++
 rtl/fire9_squeeze_ofm_writer.sv | 132 +++++++++++++
 tb/tb_fire9_squeeze_ofm_writer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fire9_squeeze_ofm_writer_if.sv
// Bundle for the fire9 squeeze OFM writer: parallel pixel input side plus
// the serial feature-map RAM write port and status flags.
interface fire9_squeeze_ofm_writer_if #(
    parameter int DSP_NO = 112,
    parameter int WIDTH  = 16,
    parameter int AW     = 13
);
    logic             sample_in;
    logic [WIDTH-1:0] ofm_in [0:DSP_NO-1];
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_wdata;
    logic             ram_feedback;
    logic             busy;
    logic             layer_done;
    logic             overflow_err;

    // Upstream / bench view: drives the pixel strobe, observes the RAM side
    modport master (
        output sample_in,
        output ofm_in,
        input  ram_we,
        input  ram_addr,
        input  ram_wdata,
        input  ram_feedback,
        input  busy,
        input  layer_done,
        input  overflow_err
    );

    modport slave (
        input  sample_in,
        input  ofm_in,
        output ram_we,
        output ram_addr,
        output ram_wdata,
        output ram_feedback,
        output busy,
        output layer_done,
        output overflow_err
    );
endinterface

// File: rtl/fire9_squeeze_ofm_writer.sv
// Serialises DSP_NO parallel squeeze outputs per pixel into a channel-major
// feature-map RAM and signals the squeeze stage once the whole layer is stored.
module fire9_squeeze_ofm_writer #(
    parameter int DSP_NO = 112,
    parameter int WIDTH  = 16,
    parameter int WOUT   = 8,
    parameter int AW     = $clog2(DSP_NO * WOUT ** 2)
) (
    input logic clk,
    input logic rst,
    fire9_squeeze_ofm_writer_if.slave bus
);

    localparam int PIXELS = WOUT * WOUT;
    localparam int CW     = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
    localparam int PW     = (PIXELS > 1) ? $clog2(PIXELS) : 1;

    localparam logic [CW-1:0] CH_LAST    = CW'(DSP_NO - 1);
    localparam logic [PW-1:0] PIX_LAST   = PW'(PIXELS - 1);
    localparam logic [AW-1:0] PLANE_STEP = AW'(PIXELS);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    ch_q, ch_d;
    logic [PW-1:0]    pix_q, pix_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             fb_q, fb_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             load;
    logic [WIDTH-1:0] shadow [0:DSP_NO-1];

    // Registered outputs describe the write of channel ch_q; the address
    // steps by one plane per channel so no multiplier is needed.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        pix_d   = pix_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fb_d    = 1'b0;
        done_d  = done_q;
        ovf_d   = ovf_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.sample_in) begin
                    load    = 1'b1;
                    state_d = DRAIN;
                    ch_d    = '0;
                    we_d    = 1'b1;
                    addr_d  = AW'(pix_q);
                    wdata_d = bus.ofm_in[0];
                end
            end
            DRAIN: begin
                if (ch_q != CH_LAST) begin
                    ch_d    = ch_q + CW'(1);
                    we_d    = 1'b1;
                    addr_d  = addr_q + PLANE_STEP;
                    wdata_d = shadow[ch_d];
                    if (bus.sample_in) ovf_d = 1'b1;
                end else if (pix_q == PIX_LAST) begin
                    state_d = DONE;
                    fb_d    = 1'b1;
                    done_d  = 1'b1;
                    if (bus.sample_in) ovf_d = 1'b1;
                end else begin
                    pix_d = pix_q + PW'(1);
                    // A strobe on the last write of a pixel chains straight into the next drain
                    if (bus.sample_in) begin
                        load    = 1'b1;
                        ch_d    = '0;
                        we_d    = 1'b1;
                        addr_d  = AW'(pix_d);
                        wdata_d = bus.ofm_in[0];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            pix_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            fb_q    <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            pix_q   <= pix_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fb_q    <= fb_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // Shadow copy frees the upstream bus while the pixel drains
    always_ff @(posedge clk) begin
        if (load) shadow <= bus.ofm_in;
    end

    assign bus.ram_we       = we_q;
    assign bus.busy         = we_q;
    assign bus.ram_addr     = addr_q;
    assign bus.ram_wdata    = wdata_q;
    assign bus.ram_feedback = fb_q;
    assign bus.layer_done   = done_q;
    assign bus.overflow_err = ovf_q;

endmodule

// File: tb/tb_fire9_squeeze_ofm_writer.sv
// Randomised self-checking bench for fire9_squeeze_ofm_writer: a queue-based
// model of expected RAM writes is compared against the DUT every cycle.
module tb_fire9_squeeze_ofm_writer;

    localparam int DSP_NO = 112;
    localparam int WIDTH  = 16;
    localparam int WOUT   = 8;
    localparam int PIXELS = WOUT * WOUT;
    localparam int AW     = 13;
    localparam int DEPTH  = DSP_NO * PIXELS;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fire9_squeeze_ofm_writer_if #(.DSP_NO(DSP_NO), .WIDTH(WIDTH), .AW(AW)) wr_if ();

    fire9_squeeze_ofm_writer #(
        .DSP_NO(DSP_NO),
        .WIDTH (WIDTH),
        .WOUT  (WOUT),
        .AW    (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(wr_if)
    );

    int check_count = 0;
    int pass_count  = 0;

    // Model: pending writes as (addr, data) queues; head is the write on the bus now
    int qaddr[$];
    int qdata[$];
    int m_pix   = 0;
    bit m_final = 1'b0;
    bit m_done  = 1'b0;
    bit m_ovf   = 1'b0;
    int e_we    = 0;
    int e_addr  = 0;
    int e_data  = 0;
    int e_fb    = 0;

    // Monitor bookkeeping
    int dut_ram [DEPTH];
    int cyc             = 0;
    int total_writes    = 0;
    int busy_cycles     = 0;
    int fb_count        = 0;
    int fb_cycle        = 0;
    int last_addr_cycle = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) pass_count++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic runModel();
        bit was_drain, was_last, final_pre, done_pre;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                qaddr.delete();
                qdata.delete();
                m_pix = 0; m_final = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
                e_we = 0; e_addr = 0; e_data = 0; e_fb = 0;
            end else begin
                was_drain = (qaddr.size() > 0);
                was_last  = (qaddr.size() == 1);
                final_pre = m_final;
                done_pre  = m_done;
                if (was_drain) begin
                    void'(qaddr.pop_front());
                    void'(qdata.pop_front());
                end
                e_fb = 0;
                if (was_last && final_pre) begin
                    m_done  = 1'b1;
                    m_final = 1'b0;
                    e_fb    = 1;
                end
                if (wr_if.sample_in && !done_pre) begin
                    if (!was_drain || (was_last && !final_pre)) begin
                        for (int c = 0; c < DSP_NO; c++) begin
                            qaddr.push_back(c * PIXELS + m_pix);
                            qdata.push_back(int'(wr_if.ofm_in[c]));
                        end
                        if (m_pix == PIXELS - 1) m_final = 1'b1;
                        m_pix++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                e_we = (qaddr.size() > 0) ? 1 : 0;
                if (e_we == 1) begin
                    e_addr = qaddr[0];
                    e_data = qdata[0];
                end
            end
        end
    endtask

    task automatic runCompare();
        int act_ctrl, exp_ctrl;
        forever begin
            @(negedge clk);
            act_ctrl = int'({wr_if.ram_we, wr_if.busy, wr_if.ram_feedback,
                             wr_if.layer_done, wr_if.overflow_err});
            exp_ctrl = (e_we << 4) | (e_we << 3) | (e_fb << 2)
                     | (int'(m_done) << 1) | int'(m_ovf);
            checkOutput("ctrl{we,busy,fb,done,ovf}", act_ctrl, exp_ctrl);
            checkOutput("ram_addr", int'(wr_if.ram_addr), e_addr);
            checkOutput("ram_wdata", int'(wr_if.ram_wdata), e_data);
        end
    endtask

    task automatic runMonitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (wr_if.ram_we) begin
                dut_ram[int'(wr_if.ram_addr)] = int'(wr_if.ram_wdata);
                total_writes++;
                if (int'(wr_if.ram_addr) == DEPTH - 1) last_addr_cycle = cyc;
            end
            if (wr_if.busy) busy_cycles++;
            if (wr_if.ram_feedback) begin
                fb_count++;
                fb_cycle = cyc;
            end
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one pixel for exactly one rising edge; data is base+ch or random
    task automatic applyStimulus(input int base, input bit rnd);
        for (int c = 0; c < DSP_NO; c++)
            wr_if.ofm_in[c] = rnd ? 16'($urandom_range(0, 65535)) : 16'(base + c);
        wr_if.sample_in = 1'b1;
        @(negedge clk);
        wr_if.sample_in = 1'b0;
    endtask

    task automatic doReset();
        #2 rst = 1'b1;
        waitCycles(3);
        #2 rst = 1'b0;
        waitCycles(1);
    endtask

    initial begin
        int wb, bb, fbb, bad, gap, k;
        rst = 1'b1;
        wr_if.sample_in = 1'b0;
        for (int c = 0; c < DSP_NO; c++) wr_if.ofm_in[c] = '0;
        fork
            runModel();
            runCompare();
            runMonitor();
        join_none

        // Reset values
        waitCycles(2);
        #1;
        checkOutput("reset ctrl", int'({wr_if.ram_we, wr_if.busy, wr_if.ram_feedback,
                                         wr_if.layer_done, wr_if.overflow_err}), 0);
        checkOutput("reset ram_addr", int'(wr_if.ram_addr), 0);
        checkOutput("reset ram_wdata", int'(wr_if.ram_wdata), 0);
        waitCycles(1);
        #2 rst = 1'b0;
        waitCycles(1);

        // Single pixel with data ch+1
        $display("[TB] single sample");
        wb = total_writes; bb = busy_cycles;
        applyStimulus(1, 1'b0);
        waitCycles(120);
        #1;
        checkOutput("single write count", total_writes - wb, DSP_NO);
        checkOutput("single busy cycles", busy_cycles - bb, DSP_NO);
        checkOutput("single ram[0]", dut_ram[0], 1);
        checkOutput("single ram[55*64]", dut_ram[55 * 64], 56);
        checkOutput("single ram[7104]", dut_ram[7104], 112);

        // Back-to-back: second strobe on the last drain cycle of pixel 0
        $display("[TB] back-to-back");
        doReset();
        wb = total_writes; bb = busy_cycles;
        applyStimulus(0, 1'b0);
        waitCycles(DSP_NO - 1);
        applyStimulus(256, 1'b0);
        waitCycles(120);
        #1;
        checkOutput("b2b write count", total_writes - wb, 2 * DSP_NO);
        checkOutput("b2b busy cycles", busy_cycles - bb, 2 * DSP_NO);
        checkOutput("b2b overflow_err", int'(wr_if.overflow_err), 0);
        checkOutput("b2b ram[1]", dut_ram[1], 256);
        checkOutput("b2b ram[7105]", dut_ram[111 * 64 + 1], 256 + 111);

        // Overflow: strobe while ch=50 is on the bus
        $display("[TB] overflow");
        doReset();
        wb = total_writes;
        applyStimulus(0, 1'b0);
        waitCycles(50);
        applyStimulus(0, 1'b1);
        waitCycles(70);
        applyStimulus(16'h3000, 1'b0);
        waitCycles(120);
        #1;
        checkOutput("ovf sticky", int'(wr_if.overflow_err), 1);
        checkOutput("ovf write count", total_writes - wb, 2 * DSP_NO);
        checkOutput("ovf next pix ram[1]", dut_ram[1], 16'h3000);
        checkOutput("ovf next pix ram[65]", dut_ram[65], 16'h3001);
        checkOutput("ovf pix2 untouched ram[2]", dut_ram[2], 0);

        // Reset in the middle of pixel 5 (ch=30 on the bus)
        $display("[TB] mid-drain reset");
        doReset();
        for (int p = 0; p < 5; p++) begin
            applyStimulus(16'h2000 + p, 1'b0);
            waitCycles(119);
        end
        applyStimulus(16'h2100, 1'b0);
        waitCycles(30);
        checkOutput("pix5 ch30 addr", int'(wr_if.ram_addr), 30 * 64 + 5);
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset ctrl", int'({wr_if.ram_we, wr_if.busy, wr_if.ram_feedback,
                                               wr_if.layer_done, wr_if.overflow_err}), 0);
        checkOutput("async reset addr", int'(wr_if.ram_addr), 0);
        checkOutput("async reset data", int'(wr_if.ram_wdata), 0);
        wb = total_writes;
        waitCycles(3);
        #2 rst = 1'b0;
        waitCycles(1);
        checkOutput("writes during reset", total_writes - wb, 0);
        applyStimulus(16'h6000, 1'b0);
        waitCycles(115);
        #1;
        checkOutput("restart ram[0]", dut_ram[0], 16'h6000);
        checkOutput("restart ram[64]", dut_ram[64], 16'h6001);

        // Full layer with random spacing and random dropped strobes
        $display("[TB] full layer");
        doReset();
        fbb = fb_count;
        for (int p = 0; p < PIXELS; p++) begin
            gap = ($urandom_range(0, 3) == 0) ? 513 : int'($urandom_range(DSP_NO, DSP_NO + 18));
            applyStimulus(p * 256, 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                k = int'($urandom_range(0, 100));
                waitCycles(k);
                applyStimulus(0, 1'b1);
                waitCycles(gap - 2 - k);
            end else begin
                waitCycles(gap - 1);
            end
        end
        waitCycles(10);
        #1;
        bad = 0;
        for (int p = 0; p < PIXELS; p++)
            for (int c = 0; c < DSP_NO; c++)
                if (dut_ram[c * PIXELS + p] != p * 256 + c) bad++;
        checkOutput("layer image mismatches", bad, 0);
        checkOutput("layer ram[7167]", dut_ram[DEPTH - 1], 16239);
        checkOutput("feedback pulses", fb_count - fbb, 1);
        checkOutput("feedback after last write", fb_cycle - last_addr_cycle, 1);
        checkOutput("layer_done level", int'(wr_if.layer_done), 1);

        // Strobes after completion are ignored
        $display("[TB] after done");
        wb = total_writes; fbb = fb_count;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1'b1);
            waitCycles(5);
        end
        #1;
        checkOutput("writes after done", total_writes - wb, 0);
        checkOutput("feedback after done", fb_count - fbb, 0);
        checkOutput("layer_done held", int'(wr_if.layer_done), 1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
